aha_sif_bank_mem: RTL
=====================

Name: aha_sif_bank_mem

Overview:
- Downstream consumer of the AXI-to-simple-interface bridge in the AhaGarnetIntegration path.
- Terminates the simple write and read channels (SIF_WR_*, SIF_RD_*) onto NUM_BANKS external 1R1W SRAM macros. Each macro is 64 bits wide with 1-cycle read latency.
- Adds an input register stage, bank decode, same-address write-to-read forwarding, out-of-window error handling and a registered read-data hold stage.
- Read latency is fixed at 3 cycles. The parent's read wait-state setting is sized to match.

Parameters:
- NUM_BANKS, 4, number of SRAM banks; power of two, 1..16.
- BANK_AW, 10, word-address width per bank (2^BANK_AW 64-bit words per bank).
- BASE_ADDR, 32'h0000_0000, byte base of the window; aligned to the window size.
- ERR_DATA, 64'hDEAD_BEEF_DEAD_BEEF, read data returned for out-of-window reads.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous active-high reset
- SIF_WR_ADDR  in  32  byte write address; bits [2:0] ignored
- SIF_WR_EN  in  8  per-byte write enables; any bit set means a write this cycle
- SIF_WR_DATA  in  64  write data
- SIF_RD_ADDR  in  32  byte read address; bits [2:0] ignored
- SIF_RD_EN  in  1  read strobe
- SIF_RD_DATA  out  64  read data; valid 3 cycles after strobe, held until next return
- BANK_WE  out  8*NUM_BANKS  byte write enables, bank b at [8b+:8]
- BANK_WADDR  out  BANK_AW*NUM_BANKS  word write address per bank
- BANK_WDATA  out  64*NUM_BANKS  write data per bank
- BANK_RE  out  NUM_BANKS  read enable per bank
- BANK_RADDR  out  BANK_AW*NUM_BANKS  word read address per bank
- BANK_RDATA  in  64*NUM_BANKS  per-bank read data, valid the cycle after BANK_RE
- ERR_CLR  in  1  synchronous clear of ERR_CNT
- ERR_CNT  out  16  saturating count of out-of-window accesses

Behaviour:
- Reset (ARESET high, asynchronous) clears:
  - all pipeline valids and stage registers;
  - SIF_RD_DATA to 0;
  - ERR_CNT to 0.
  All BANK_* outputs are 0 during reset.
- Address map:
  - word index = addr[3 +: BANK_AW];
  - bank = addr[3+BANK_AW +: log2(NUM_BANKS)];
  - in window iff (addr - BASE_ADDR) < NUM_BANKS * 2^BANK_AW * 8.
- Stage 1, registered at the edge ending cycle T:
  - wr_v1 = |SIF_WR_EN & in-window; also captures word, bank, strobes and data;
  - rd_v1 = SIF_RD_EN; also captures word, bank and an in-window flag.
- Cycle T+1, combinational from stage 1:
  - if wr_v1, drive BANK_WE/WADDR/WDATA of the decoded bank only; other banks' WE = 0;
  - if rd_v1 & in-window, assert BANK_RE of the decoded bank only, with BANK_RADDR.
- Stage 2, registered at the end of T+1:
  - rd_v2, bank2, oow2 (out-of-window);
  - fwd_mask2 = wr strobes when wr_v1 & rd_v1 hit the same bank and word, else 0;
  - fwd_data2 = the corresponding write data.
- Cycle T+2: merge BANK_RDATA[bank2] byte-wise. Where fwd_mask2 is set, take fwd_data2 (write-first); else take SRAM data. If oow2, use ERR_DATA.
- Stage 3: at the end of T+2, if rd_v2, register the merged value into SIF_RD_DATA. SIF_RD_DATA is valid in cycle T+3.
- SIF_RD_DATA holds its value while no read returns.
- Throughput: one read and one write per cycle, back-to-back; no backpressure exists.
- Reads and writes to different addresses in the same cycle are independent.
- A write in a cycle before a read to the same word is visible to that read through the SRAM.
- A write in a cycle after the read is not visible to it.
- Out-of-window writes are dropped; no bank activity.
- Out-of-window reads issue no BANK_RE and return ERR_DATA at normal latency.
- ERR_CNT:
  - +1 for each cycle with an out-of-window write, +1 for an out-of-window read; +2 if both in one cycle;
  - saturates at 16'hFFFF;
  - ERR_CLR has priority over increments in the same cycle.
- Reset mid-operation: in-flight reads are discarded and no return occurs. The first access after deassertion behaves as from idle.

Decomposition:
- Shared package aha_sif_pkg holds:
  - localparam SIF_RD_LAT = 3;
  - SIF data/strobe widths (64/8);
  - the byte-merge function, which is reused by any future SIF consumer.
- One natural sub-module, aha_sif_bank_decode: combinational window check plus bank/word split, instantiated twice (write and read paths).

Test Plan:
- Reset: assert ARESET mid-stream with a read in flight -> SIF_RD_DATA = 0, ERR_CNT = 0, BANK_WE/BANK_RE = 0; no return after release.
- Basic write/read: write 64'h0123_4567_89AB_CDEF to BASE+0x808 (bank 0, word 0x101 with defaults), strobes 8'hFF; read the same address later -> BANK_WE[7:0] = FF one cycle after the write; SIF_RD_DATA = written value exactly 3 cycles after the read strobe.
- Collision forwarding: preload word with 64'h1111_1111_1111_1111; same cycle write 64'hAAAA_AAAA_AAAA_AAAA with strobe 8'h0F and read the same address -> SIF_RD_DATA = 64'h1111_1111_AAAA_AAAA.
- Back-to-back reads: read banks 0,1,2,3 on consecutive cycles -> four returns on consecutive cycles, correct per bank; value held afterwards.
- Out-of-window: write and read at BASE+0x8000 in the same cycle -> no BANK_WE/BANK_RE; SIF_RD_DATA = ERR_DATA at +3; ERR_CNT = 2. Pulse ERR_CLR -> ERR_CNT = 0.
- Saturation: force 70000 out-of-window reads -> ERR_CNT = 16'hFFFF, stays there.

Source files
------------

// File: rtl/aha_sif_bank_mem_pkg.sv
// aha_sif_pkg: shared SIF widths, read latency and the byte-merge helper
// used by SIF consumers to overlay strobed write bytes onto read data.
package aha_sif_pkg;
    localparam int SIF_RD_LAT = 3;
    localparam int SIF_DW = 64;
    localparam int SIF_SW = SIF_DW / 8;
    typedef logic [SIF_DW-1:0] sif_data_t;
    typedef logic [SIF_SW-1:0] sif_strb_t;
    function automatic sif_data_t sif_merge(sif_data_t base, sif_data_t upd, sif_strb_t mask);
        sif_data_t r;
        for (int i = 0; i < SIF_SW; i++) r[8*i +: 8] = mask[i] ? upd[8*i +: 8] : base[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/aha_sif_bank_mem_if.sv
// aha_sif_bank_mem_if: simple write/read channel between the AXI bridge
// (master) and the banked memory (slave).
interface aha_sif_bank_mem_if;
    import aha_sif_pkg::*;
    logic [31:0] SIF_WR_ADDR;
    sif_strb_t   SIF_WR_EN;
    sif_data_t   SIF_WR_DATA;
    logic [31:0] SIF_RD_ADDR;
    logic        SIF_RD_EN;
    sif_data_t   SIF_RD_DATA;
    modport master (output SIF_WR_ADDR, SIF_WR_EN, SIF_WR_DATA, SIF_RD_ADDR, SIF_RD_EN, input SIF_RD_DATA);
    modport slave (input SIF_WR_ADDR, SIF_WR_EN, SIF_WR_DATA, SIF_RD_ADDR, SIF_RD_EN, output SIF_RD_DATA);
endinterface

// File: rtl/aha_sif_bank_mem_decode.sv
// aha_sif_bank_decode: window check and bank/word split of a SIF byte address.
module aha_sif_bank_decode #(
    parameter int          NUM_BANKS = 4,
    parameter int          BANK_AW   = 10,
    parameter int          BW        = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic [31:0]        addr,
    output logic               in_win,
    output logic [BANK_AW-1:0] word,
    output logic [BW-1:0]      bank
);
    localparam logic [32:0] WIN_BYTES = 33'(NUM_BANKS) << (BANK_AW + 3);
    logic [31:0] off;
    assign off    = addr - BASE_ADDR;
    assign in_win = {1'b0, off} < WIN_BYTES;
    assign word   = addr[3 +: BANK_AW];
    assign bank   = NUM_BANKS > 1 ? addr[3+BANK_AW +: BW] : '0;
endmodule

// File: rtl/aha_sif_bank_mem.sv
// aha_sif_bank_mem: terminates the SIF write/read channels onto banked 1R1W
// SRAMs with a fixed 3-cycle read latency and same-cycle write forwarding.
module aha_sif_bank_mem
    import aha_sif_pkg::*;
#(
    parameter int          NUM_BANKS = 4,
    parameter int          BANK_AW   = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [63:0] ERR_DATA  = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    aha_sif_bank_mem_if.slave            sif,
    output logic [8*NUM_BANKS-1:0]       BANK_WE,
    output logic [BANK_AW*NUM_BANKS-1:0] BANK_WADDR,
    output logic [64*NUM_BANKS-1:0]      BANK_WDATA,
    output logic [NUM_BANKS-1:0]         BANK_RE,
    output logic [BANK_AW*NUM_BANKS-1:0] BANK_RADDR,
    input  logic [64*NUM_BANKS-1:0]      BANK_RDATA,
    input  logic                         ERR_CLR,
    output logic [15:0]                  ERR_CNT
);
    localparam int BW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
    typedef struct packed {
        logic               wr_v;
        logic [BANK_AW-1:0] wr_word;
        logic [BW-1:0]      wr_bank;
        sif_strb_t          wr_strb;
        sif_data_t          wr_data;
        logic               rd_v;
        logic               rd_win;
        logic [BANK_AW-1:0] rd_word;
        logic [BW-1:0]      rd_bank;
    } s1_t;
    typedef struct packed {
        logic          rd_v;
        logic          oow;
        logic [BW-1:0] bank;
        sif_strb_t     fwd_mask;
        sif_data_t     fwd_data;
    } s2_t;
    s1_t                s1_q, s1_d;
    s2_t                s2_q, s2_d;
    sif_data_t          rd_data_q, rd_data_d, merged;
    logic [15:0]        err_cnt_q, err_cnt_d;
    logic [16:0]        err_sum;
    logic               wr_win, rd_win, fwd_hit;
    logic [BANK_AW-1:0] wr_word, rd_word;
    logic [BW-1:0]      wr_bank, rd_bank;

    aha_sif_bank_decode #(.NUM_BANKS(NUM_BANKS), .BANK_AW(BANK_AW), .BW(BW), .BASE_ADDR(BASE_ADDR)) u_wr_dec (
        .addr(sif.SIF_WR_ADDR), .in_win(wr_win), .word(wr_word), .bank(wr_bank)
    );
    aha_sif_bank_decode #(.NUM_BANKS(NUM_BANKS), .BANK_AW(BANK_AW), .BW(BW), .BASE_ADDR(BASE_ADDR)) u_rd_dec (
        .addr(sif.SIF_RD_ADDR), .in_win(rd_win), .word(rd_word), .bank(rd_bank)
    );

    always_comb begin
        s1_d = '{wr_v: |sif.SIF_WR_EN & wr_win, wr_word: wr_word, wr_bank: wr_bank,
                 wr_strb: sif.SIF_WR_EN, wr_data: sif.SIF_WR_DATA,
                 rd_v: sif.SIF_RD_EN, rd_win: rd_win, rd_word: rd_word, rd_bank: rd_bank};
        // A same-cycle write to the read word wins over the SRAM's old contents.
        fwd_hit = s1_q.wr_v & s1_q.rd_v & (s1_q.wr_bank == s1_q.rd_bank) & (s1_q.wr_word == s1_q.rd_word);
        s2_d = '{rd_v: s1_q.rd_v, oow: ~s1_q.rd_win, bank: s1_q.rd_bank,
                 fwd_mask: fwd_hit ? s1_q.wr_strb : '0, fwd_data: s1_q.wr_data};
        merged = s2_q.oow ? ERR_DATA : sif_merge(BANK_RDATA[64*s2_q.bank +: 64], s2_q.fwd_data, s2_q.fwd_mask);
        rd_data_d = s2_q.rd_v ? merged : rd_data_q;
        err_sum = 17'(err_cnt_q) + 17'(|sif.SIF_WR_EN & ~wr_win) + 17'(sif.SIF_RD_EN & ~rd_win);
        err_cnt_d = ERR_CLR ? '0 : err_sum[16] ? 16'hFFFF : err_sum[15:0];
        BANK_WE = '0;
        BANK_WADDR = '0;
        BANK_WDATA = '0;
        BANK_RE = '0;
        BANK_RADDR = '0;
        if (s1_q.wr_v) begin
            BANK_WE[8*s1_q.wr_bank +: 8] = s1_q.wr_strb;
            BANK_WADDR[BANK_AW*s1_q.wr_bank +: BANK_AW] = s1_q.wr_word;
            BANK_WDATA[64*s1_q.wr_bank +: 64] = s1_q.wr_data;
        end
        if (s1_q.rd_v & s1_q.rd_win) begin
            BANK_RE[s1_q.rd_bank] = 1'b1;
            BANK_RADDR[BANK_AW*s1_q.rd_bank +: BANK_AW] = s1_q.rd_word;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            s1_q <= '0;
            s2_q <= '0;
            rd_data_q <= '0;
            err_cnt_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            rd_data_q <= rd_data_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign sif.SIF_RD_DATA = rd_data_q;
    assign ERR_CNT = err_cnt_q;
endmodule
